// File: rtl/mdu_ctrl.sv
// mdu_ctrl: multiply/divide sequencer for the E stage.
// Runs mult/multu/div/divu over a fixed busy period, owns HI/LO, and
// executes mthi/mtlo. It also raises the D-stage stall whenever a new MDU
// instruction would collide with an operation in flight.
//
// Ports:
//   clk, reset     - clock, synchronous active-high reset
//   E_MDUop        - 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo
//   E_MDU_start    - E-stage instruction is mult/multu/div/divu
//   E_MDUout_sel   - read select, 0 = HI, 1 = LO
//   E_A, E_B       - forwarded rs / rt operands
//   E_req          - flush of the E-stage instruction
//   D_use_MDU      - D-stage instruction touches the MDU
//   E_MDU_busy     - operation in flight
//   MDU_stall      - stall request to the hazard unit
//   E_MDU_out      - selected HI or LO
//
// Optional feature: define MDU_ZERO_LATENCY_EN to commit mult/div results on
// the start edge (no busy period, no stall).
module mdu_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  E_MDUop,
  input  logic        E_MDU_start,
  input  logic        E_MDUout_sel,
  input  logic [31:0] E_A,
  input  logic [31:0] E_B,
  input  logic        E_req,
  input  logic        D_use_MDU,
  output logic        E_MDU_busy,
  output logic        MDU_stall,
  output logic [31:0] E_MDU_out
);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;

  typedef enum logic {IDLE, BUSY} state_e;

  state_e      state_q;
  logic [3:0]  cnt_q;
  logic [31:0] hi_q, lo_q;
  logic [31:0] pend_hi_q, pend_lo_q;
  logic        pend_wr_q;

  // Decoded request and the result it would produce this cycle
  logic        is_arith, is_mult, is_sdiv, is_mt;
  logic [63:0] res_d;
  logic        res_wr_d;
  logic [63:0] prod;
  logic [31:0] div_a, div_b, dvs, uq, ur;

  always_comb begin
    is_arith = (E_MDUop >= OP_MULT) && (E_MDUop <= OP_DIVU);
    is_mult  = (E_MDUop == OP_MULT) || (E_MDUop == OP_MULTU);
    is_sdiv  = (E_MDUop == OP_DIV);
    is_mt    = (E_MDUop == OP_MTHI) || (E_MDUop == OP_MTLO);

    // Sign-extend to 64 bits for mult so the truncated product is the
    // two's-complement signed result; zero-extend for multu.
    prod = {{32{(E_MDUop == OP_MULT) & E_A[31]}}, E_A} *
           {{32{(E_MDUop == OP_MULT) & E_B[31]}}, E_B};

    // Signed divide on magnitudes; 0x80000000 / -1 falls out as
    // quotient 0x80000000, remainder 0 with no special case.
    div_a = (is_sdiv && E_A[31]) ? (~E_A + 32'd1) : E_A;
    div_b = (is_sdiv && E_B[31]) ? (~E_B + 32'd1) : E_B;
    dvs   = (div_b == 32'd0) ? 32'd1 : div_b;  // result discarded when 0
    uq    = div_a / dvs;
    ur    = div_a % dvs;

    res_d    = prod;
    res_wr_d = 1'b1;
    if (!is_mult) begin
      res_d[31:0]  = (is_sdiv && (E_A[31] ^ E_B[31])) ? (~uq + 32'd1) : uq;
      res_d[63:32] = (is_sdiv && E_A[31]) ? (~ur + 32'd1) : ur;
      res_wr_d     = (E_B != 32'd0);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= 4'd0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
      pend_hi_q <= 32'd0;
      pend_lo_q <= 32'd0;
      pend_wr_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (E_MDU_start && !E_req && is_arith) begin
`ifdef MDU_ZERO_LATENCY_EN
            if (res_wr_d) begin
              hi_q <= res_d[63:32];
              lo_q <= res_d[31:0];
            end
`else
            pend_hi_q <= res_d[63:32];
            pend_lo_q <= res_d[31:0];
            pend_wr_q <= res_wr_d;
            cnt_q     <= is_mult ? 4'(MULT_CYCLES) : 4'(DIV_CYCLES);
            state_q   <= BUSY;
`endif
          end else if (is_mt && !E_req) begin
            if (E_MDUop == OP_MTHI) hi_q <= E_A;
            else                    lo_q <= E_A;
          end
        end
        BUSY: begin
          // New requests are ignored here; the in-flight op always finishes.
          cnt_q <= cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            if (pend_wr_q) begin
              hi_q <= pend_hi_q;
              lo_q <= pend_lo_q;
            end
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign E_MDU_busy = (state_q == BUSY);
`ifdef MDU_ZERO_LATENCY_EN
  assign MDU_stall  = 1'b0;
`else
  assign MDU_stall  = D_use_MDU & (E_MDU_busy | (E_MDU_start & ~E_req));
`endif
  assign E_MDU_out  = E_MDUout_sel ? lo_q : hi_q;

endmodule

// File: doc/mdu_ctrl.md
# mdu_ctrl

Sequencer for the pipeline's multiply/divide resource. It sits in the E stage next to the ALU and accepts the MDU control fields decoded in D: `MDUop`, `MDU_start`, `MDUout_sel`. It runs mult/multu/div/divu over a fixed multi-cycle latency, owns the HI/LO registers and executes mthi/mtlo. It also raises the D-stage stall whenever a new MDU instruction would collide with an operation in flight.

## Interface
Parameters:
- `MULT_CYCLES`, default 5: busy cycles for mult/multu; legal range 1..15.
- `DIV_CYCLES`, default 10: busy cycles for div/divu; legal range 1..15.

Ports:
- `clk` input, 1 bit: the single clock.
- `reset` input, 1 bit: synchronous, active-high.
- `E_MDUop` input, 4 bits: operation code.
  - 0001 mult, 0010 multu, 0011 div, 0100 divu.
  - 0101 mthi, 0110 mtlo.
  - Any other value: no operation.
- `E_MDU_start` input, 1 bit: E-stage instruction is mult/multu/div/divu.
- `E_MDUout_sel` input, 1 bit: read select; 0 = HI, 1 = LO.
- `E_A` input, 32 bits: rs operand, already forwarded.
- `E_B` input, 32 bits: rt operand, already forwarded.
- `E_req` input, 1 bit: exception/interrupt flush of the E-stage instruction.
- `D_use_MDU` input, 1 bit: D-stage instruction is mult/multu/div/divu/mfhi/mflo/mthi/mtlo.
- `E_MDU_busy` output, 1 bit: operation in flight.
- `MDU_stall` output, 1 bit: stall request to the hazard unit.
- `E_MDU_out` output, 32 bits: HI or LO, selected by `E_MDUout_sel`.

## Operation
- **Reset values:**
  - State IDLE; `E_MDU_busy`=0; `MDU_stall`=0.
  - HI=LO=0, so `E_MDU_out`=0.
  - Cycle counter=0; pending result registers=0.
- **States:** IDLE and BUSY.
- **IDLE → BUSY** when `E_MDU_start`=1, `E_req`=0 and `E_MDUop` is 0001..0100. On that edge:
  - Compute the 64-bit result from `E_A` and `E_B` into pending registers.
  - Load the counter with `MULT_CYCLES` or `DIV_CYCLES`.
- **BUSY:**
  - The counter decrements every cycle.
  - When the counter is 1, the next edge writes pending HI/LO and returns to IDLE.
- **Arithmetic:**
  - mult: signed 32×32 → 64 bits; HI = bits [63:32], LO = bits [31:0].
  - multu: unsigned 32×32 → 64 bits, same HI/LO split.
  - div: LO = quotient truncated toward zero; HI = remainder, taking the sign of the dividend.
  - div 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
  - divu: unsigned quotient in LO, remainder in HI.
  - Divisor 0 (div or divu): the full busy period still runs, but HI/LO are not written.
- **mthi/mtlo** (op 0101/0110, `E_req`=0, IDLE): write `E_A` into HI or LO on the edge, in one cycle.
- **Flush:** `E_req`=1 suppresses start, mthi and mtlo in that cycle. An operation already in BUSY runs to completion regardless of `E_req`.
- **Illegal overlap:** start or mthi/mtlo arriving while BUSY is ignored, and the in-flight operation is undisturbed. The stall logic prevents this in normal use.
- **`MDU_stall`** = `D_use_MDU` & (`E_MDU_busy` | (`E_MDU_start` & ~`E_req`)). It is combinational.
- **`E_MDU_out`:** combinational from the HI/LO registers. It never exposes pending values.

## Timing
- Start accepted on the edge ending cycle t.
- `E_MDU_busy`=1 during cycles t+1 .. t+N, where N is the configured cycle count.
- HI/LO are updated on the edge ending cycle t+N.
- mfhi/mflo in E during cycle t+N+1 reads the new value.
- `MDU_stall` is high during cycle t whenever `D_use_MDU`=1, and likewise during t+1..t+N.
- mthi/mtlo: the value is visible on `E_MDU_out` from the next cycle.
- Reset asserted in any cycle, including mid-BUSY: the next cycle is IDLE with HI=LO=0 and the pending result discarded.
- Reset has priority over every other input.

## Configuration
- **`MDU_ZERO_LATENCY_EN` defined:**
  - `MULT_CYCLES` and `DIV_CYCLES` are ignored.
  - Accepted mult/div write HI/LO on the start edge.
  - `E_MDU_busy` is constantly 0, and `MDU_stall` reduces to 0.
  - Divide-by-zero still leaves HI/LO unchanged.
- **Undefined (default):** multi-cycle behaviour as specified above.

## Test plan
- Reset, then mult with `E_A`=0xFFFFFFFF, `E_B`=2 → busy exactly 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFE.
- multu with the same operands → HI=0x00000001, LO=0xFFFFFFFE.
- div with `E_A`=0xFFFFFFF9 (-7), `E_B`=2 → busy 10 cycles, with `D_use_MDU`=1 held so that `MDU_stall`=1 for all 10 cycles. Result LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- mthi 0x12345678, then divu by 0 → 10 busy cycles and HI stays 0x12345678. Then div 0x80000000/0xFFFFFFFF → LO=0x80000000, HI=0.
- Start with `E_req`=1 → busy stays 0 and HI/LO unchanged. mtlo with `E_req`=1 → LO unchanged.
- Start mult, assert `reset` in busy cycle 3 → next cycle busy=0 and `E_MDU_out`=0; no HI/LO write occurs afterwards.
